// File: rtl/imem_loader_if.sv
// Word stream from the program source plus the byte RAM write port of imem_loader.
interface imem_loader_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 6
);
   logic                  wr_valid;
   logic [31:0]           wr_word;
   logic                  wr_last;
   logic                  wr_ready;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;

   // master is the program source, which also observes the RAM write port
   modport master (
      output wr_valid, wr_word, wr_last,
      input  wr_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  wr_valid, wr_word, wr_last,
      output wr_ready, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/imem_loader.sv
// Loads 32-bit instruction words into a byte-wide big-endian instruction RAM,
// one byte per cycle, MSB first, from a word-aligned base address.
module imem_loader #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 6,
   parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   imem_loader_if.slave          bus,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [ADDR_WIDTH-2:0] word_count
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WAIT  = 3'd1;
   localparam logic [2:0] S_WRITE = 3'd2;
   localparam logic [2:0] S_DONE  = 3'd3;
   localparam logic [2:0] S_ERR   = 3'd4;

   localparam logic [ADDR_WIDTH-2:0] WC_LAST = (ADDR_WIDTH-1)'(RAM_DEPTH/4 - 1);

   logic [2:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d, ptr_inc;
   logic [1:0]            byte_idx_q, byte_idx_d;
   logic                  full_q, full_d;
   logic [31:0]           word_q, word_d;
   logic                  last_q, last_d;
   logic [ADDR_WIDTH-2:0] word_count_q, word_count_d;
   logic                  mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic                  unused_base_lsbs;

   function automatic logic [DATA_WIDTH-1:0] byte_sel(input logic [31:0] w,
                                                      input logic [1:0]  idx);
      logic [DATA_WIDTH-1:0] b;
      case (idx)
         2'd0:    b = w[31:24];
         2'd1:    b = w[23:16];
         2'd2:    b = w[15:8];
         default: b = w[7:0];
      endcase
      return b;
   endfunction

   assign ptr_inc          = ptr_q + 1'b1;
   assign unused_base_lsbs = ^base_addr[1:0];

   // The RAM port is registered one cycle ahead: the byte shown during a WRITE
   // cycle is the one the RAM captures at the end of that cycle.
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      byte_idx_d   = byte_idx_q;
      full_d       = full_q;
      word_d       = word_q;
      last_d       = last_q;
      word_count_d = word_count_q;
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;

      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               ptr_d        = {base_addr[ADDR_WIDTH-1:2], 2'b00};
               word_count_d = '0;
               full_d       = 1'b0;
               state_d      = S_WAIT;
            end
         end
         S_WAIT: begin
            if (bus.wr_valid) begin
               if (full_q) begin
                  state_d = S_ERR;
               end else begin
                  word_d      = bus.wr_word;
                  last_d      = bus.wr_last;
                  byte_idx_d  = 2'd0;
                  mem_we_d    = 1'b1;
                  mem_addr_d  = ptr_q;
                  mem_wdata_d = byte_sel(bus.wr_word, 2'd0);
                  state_d     = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            ptr_d = ptr_inc;
            if (ptr_inc == '0) begin
               full_d = 1'b1;
            end
            if (byte_idx_q != 2'd3) begin
               byte_idx_d  = byte_idx_q + 2'd1;
               mem_we_d    = 1'b1;
               mem_addr_d  = ptr_inc;
               mem_wdata_d = byte_sel(word_q, byte_idx_q + 2'd1);
            end else begin
               // a full-RAM session brings the count back to zero
               word_count_d = (word_count_q == WC_LAST) ? '0 : word_count_q + 1'b1;
               state_d      = last_q ? S_DONE : S_WAIT;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         ptr_q        <= '0;
         byte_idx_q   <= '0;
         full_q       <= 1'b0;
         last_q       <= 1'b0;
         word_count_q <= '0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         byte_idx_q   <= byte_idx_d;
         full_q       <= full_d;
         last_q       <= last_d;
         word_count_q <= word_count_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
      end
   end

   always_ff @(posedge clk) begin
      word_q <= word_d;
   end

   assign bus.wr_ready  = (state_q == S_WAIT);
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign busy          = (state_q == S_WAIT) || (state_q == S_WRITE);
   assign done          = (state_q == S_DONE);
   assign error         = (state_q == S_ERR);
   assign word_count    = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a behavioural byte RAM on the write port.
`timescale 1ns/1ps
module tb_imem_loader;
   localparam int AW = 6;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [AW-1:0] base_addr;
   logic          busy, done, error;
   logic [AW-2:0] word_count;

   int          tests = 0;
   int          fails = 0;
   int unsigned cyc = 0;
   int unsigned we_cnt = 0;
   logic        ram_init = 1'b0;
   logic [7:0]  ram [64];

   imem_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   imem_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .base_addr  (base_addr),
      .bus        (bus),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!ram_init) begin
         for (int i = 0; i < 64; i++) ram[i] <= 8'hEE;
         ram_init <= 1'b1;
      end else if (bus.mem_we === 1'b1) begin
         ram[bus.mem_addr] <= bus.mem_wdata;
         we_cnt <= we_cnt + 1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ram_word(input int a);
      return {ram[6'(a)], ram[6'(a + 1)], ram[6'(a + 2)], ram[6'(a + 3)]};
   endfunction

   task automatic pulse_start(input logic [AW-1:0] b);
      start     = 1'b1;
      base_addr = b;
      @(negedge clk);
      start     = 1'b0;
   endtask

   // returns on the negedge just after the handshake edge
   task automatic send_word(input logic [31:0] w, input logic last);
      int n;
      bus.wr_word  = w;
      bus.wr_last  = last;
      bus.wr_valid = 1'b1;
      n = 0;
      while (bus.wr_ready !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) chk("wr_ready_timeout", 64'd0, 64'd1);
      @(negedge clk);
      bus.wr_valid = 1'b0;
   endtask

   task automatic wait_end();
      int n;
      n = 0;
      while (done !== 1'b1 && error !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (n >= 60) chk("end_timeout", 64'd0, 64'd1);
   endtask

   initial begin
      int unsigned w0;
      int unsigned acc [3];
      logic [31:0] ws [3];
      int n;

      rst_n        = 1'b0;
      start        = 1'b0;
      base_addr    = '0;
      bus.wr_valid = 1'b0;
      bus.wr_word  = '0;
      bus.wr_last  = 1'b0;
      repeat (3) @(negedge clk);

      chk("rst_wr_ready",   64'(bus.wr_ready),  64'd0);
      chk("rst_mem_we",     64'(bus.mem_we),    64'd0);
      chk("rst_mem_addr",   64'(bus.mem_addr),  64'd0);
      chk("rst_mem_wdata",  64'(bus.mem_wdata), 64'd0);
      chk("rst_busy",       64'(busy),          64'd0);
      chk("rst_done",       64'(done),          64'd0);
      chk("rst_error",      64'(error),         64'd0);
      chk("rst_word_count", 64'(word_count),    64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // two-word program at base 0
      pulse_start(6'd0);
      chk("t1_busy",     64'(busy),         64'd1);
      chk("t1_wr_ready", 64'(bus.wr_ready), 64'd1);
      w0 = we_cnt;
      send_word(32'h08000005, 1'b0);
      chk("t1_b0_we",    64'(bus.mem_we),    64'd1);
      chk("t1_b0_addr",  64'(bus.mem_addr),  64'd0);
      chk("t1_b0_wdata", 64'(bus.mem_wdata), 64'h08);
      send_word(32'h0020502A, 1'b1);
      wait_end();
      chk("t1_ram0",    64'(ram_word(0)),    64'h08000005);
      chk("t1_ram4",    64'(ram_word(4)),    64'h0020502A);
      chk("t1_done",    64'(done),           64'd1);
      chk("t1_count",   64'(word_count),     64'd2);
      chk("t1_error",   64'(error),          64'd0);
      chk("t1_busy_lo", 64'(busy),           64'd0);
      chk("t1_we_cnt",  64'(we_cnt - w0),    64'd8);

      // unaligned base is forced to a word boundary
      pulse_start(6'd6);
      send_word(32'h00201020, 1'b1);
      wait_end();
      chk("t2_ram4",  64'(ram_word(4)), 64'h00201020);
      chk("t2_ram0",  64'(ram_word(0)), 64'h08000005);
      chk("t2_ram8",  64'(ram[8]),      64'hEE);
      chk("t2_done",  64'(done),        64'd1);
      chk("t2_count", 64'(word_count),  64'd1);

      // wr_valid held high across three words
      ws[0] = 32'hA1B2C3D4;
      ws[1] = 32'h55667788;
      ws[2] = 32'h0F1E2D3C;
      pulse_start(6'd16);
      w0 = we_cnt;
      bus.wr_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.wr_word = ws[i];
         bus.wr_last = (i == 2);
         n = 0;
         while (bus.wr_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
         end
         if (n >= 40) chk("t3_ready_timeout", 64'd0, 64'd1);
         acc[i] = cyc;
         @(negedge clk);
         if (i == 0) begin
            chk("t3_b0_we",    64'(bus.mem_we),    64'd1);
            chk("t3_b0_addr",  64'(bus.mem_addr),  64'd16);
            chk("t3_b0_wdata", 64'(bus.mem_wdata), 64'hA1);
         end
         for (int k = 0; k < 4; k++) begin
            chk("t3_ready_low", 64'(bus.wr_ready), 64'd0);
            @(negedge clk);
         end
      end
      bus.wr_valid = 1'b0;
      wait_end();
      chk("t3_gap01",  64'(acc[1] - acc[0]), 64'd5);
      chk("t3_gap12",  64'(acc[2] - acc[1]), 64'd5);
      chk("t3_we_cnt", 64'(we_cnt - w0),     64'd12);
      chk("t3_ram16",  64'(ram_word(16)),    64'hA1B2C3D4);
      chk("t3_ram20",  64'(ram_word(20)),    64'h55667788);
      chk("t3_ram24",  64'(ram_word(24)),    64'h0F1E2D3C);
      chk("t3_done",   64'(done),            64'd1);
      chk("t3_count",  64'(word_count),      64'd3);

      // overflow past the top of RAM
      pulse_start(6'd60);
      w0 = we_cnt;
      send_word(32'hCAFEF00D, 1'b0);
      send_word(32'h12345678, 1'b0);
      chk("t4_mem_we", 64'(bus.mem_we),   64'd0);
      chk("t4_error",  64'(error),        64'd1);
      chk("t4_done",   64'(done),         64'd0);
      chk("t4_busy",   64'(busy),         64'd0);
      chk("t4_count",  64'(word_count),   64'd1);
      chk("t4_ram60",  64'(ram_word(60)), 64'hCAFEF00D);
      chk("t4_ram0",   64'(ram_word(0)),  64'h08000005);
      chk("t4_we_cnt", 64'(we_cnt - w0),  64'd4);

      // reset in the middle of a word
      pulse_start(6'd32);
      send_word(32'h11223344, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("t5_mem_we",   64'(bus.mem_we),   64'd0);
      chk("t5_busy",     64'(busy),         64'd0);
      chk("t5_wr_ready", 64'(bus.wr_ready), 64'd0);
      chk("t5_count",    64'(word_count),   64'd0);
      chk("t5_ram32",    64'(ram[32]),      64'h11);
      chk("t5_ram33",    64'(ram[33]),      64'h22);
      rst_n = 1'b1;
      @(negedge clk);
      pulse_start(6'd0);
      send_word(32'hDEADBEEF, 1'b1);
      wait_end();
      chk("t5_ram0",  64'(ram_word(0)), 64'hDEADBEEF);
      chk("t5_done",  64'(done),        64'd1);
      chk("t5_count", 64'(word_count),  64'd1);

      // start during WRITE is ignored; start during DONE restarts
      pulse_start(6'd40);
      send_word(32'hAAAA5555, 1'b0);
      pulse_start(6'd0);
      chk("t6_busy_write", 64'(busy), 64'd1);
      send_word(32'h0BADC0DE, 1'b1);
      wait_end();
      chk("t6_ram40", 64'(ram_word(40)), 64'hAAAA5555);
      chk("t6_ram44", 64'(ram_word(44)), 64'h0BADC0DE);
      chk("t6_ram0",  64'(ram_word(0)),  64'hDEADBEEF);
      chk("t6_count", 64'(word_count),   64'd2);
      chk("t6_done",  64'(done),         64'd1);
      pulse_start(6'd48);
      chk("t6_rs_done",     64'(done),         64'd0);
      chk("t6_rs_count",    64'(word_count),   64'd0);
      chk("t6_rs_busy",     64'(busy),         64'd1);
      chk("t6_rs_wr_ready", 64'(bus.wr_ready), 64'd1);
      send_word(32'h00000001, 1'b1);
      wait_end();
      chk("t6_ram48", 64'(ram_word(48)), 64'h00000001);

      // exactly filling the RAM with a last word ends in DONE
      pulse_start(6'd0);
      w0 = we_cnt;
      for (int i = 0; i < 16; i++) begin
         send_word(32'hA0000000 | 32'(i), i == 15);
      end
      wait_end();
      chk("t7_done",   64'(done),         64'd1);
      chk("t7_error",  64'(error),        64'd0);
      chk("t7_count",  64'(word_count),   64'd0);
      chk("t7_ram0",   64'(ram_word(0)),  64'hA0000000);
      chk("t7_ram60",  64'(ram_word(60)), 64'hA000000F);
      chk("t7_we_cnt", 64'(we_cnt - w0),  64'd64);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the byte-wide, big-endian instruction memory.
- Accepts 32-bit instruction words over a valid/ready stream.
- Writes each word to an external byte RAM write port as four consecutive bytes, MSB byte first, at increasing addresses from a word-aligned base.
- Used to load programs into instruction memory before the MIPS core runs; replaces hard-coded memory initialisation.

Parameters:
- DATA_WIDTH, 8: byte-lane width of the RAM; fixed at 8, other values unsupported.
- ADDR_WIDTH, 6: byte-address width of the RAM.
- RAM_DEPTH, 1 << ADDR_WIDTH: number of bytes in the RAM.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; begins a load session; honoured only in IDLE, DONE or ERR.
- base_addr  in  ADDR_WIDTH  start byte address, sampled on accepted start; bits [1:0] forced to 0.
- wr_valid  in  1  wr_word / wr_last valid.
- wr_word  in  32  instruction word.
- wr_last  in  1  marks final word of the session.
- wr_ready  out  1  loader can accept a word this cycle.
- mem_we  out  1  byte write strobe to RAM.
- mem_addr  out  ADDR_WIDTH  byte address of write.
- mem_wdata  out  DATA_WIDTH  byte to write.
- busy  out  1  session in progress (WAIT_WORD or WRITE).
- done  out  1  session finished after wr_last word fully written.
- error  out  1  overflow: word offered after RAM top reached.
- word_count  out  ADDR_WIDTH-1  words fully written this session.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - State goes to IDLE.
  - All outputs go to 0: wr_ready, mem_we, mem_addr, mem_wdata, busy, done, error, word_count.
  - Internal pointer, byte index and full flag are cleared.
  - Bytes already written stay in the RAM; no rollback.
- States: IDLE, WAIT_WORD, WRITE, DONE, ERR.
- IDLE/DONE/ERR + start=1:
  - ptr <= {base_addr[ADDR_WIDTH-1:2], 2'b00}.
  - word_count, done, error and full cleared.
  - Next state WAIT_WORD.
- start while busy=1 is ignored.
- WAIT_WORD:
  - wr_ready=1, busy=1.
  - A handshake occurs when wr_valid && wr_ready.
  - On handshake with full=0: latch wr_word and wr_last, set byte index to 0, go to WRITE.
  - On handshake with full=1: discard the word, no mem_we, go to ERR.
- WRITE:
  - wr_ready=0, busy=1, mem_we=1, mem_addr=ptr.
  - mem_wdata is word[31:24], [23:16], [15:8], [7:0] for byte index 0..3.
  - ptr increments by 1 each cycle, modulo RAM_DEPTH.
  - After byte index 3: word_count += 1.
  - full <= 1 if the ptr increment wrapped to 0.
  - Then: latched last=1 -> DONE; else -> WAIT_WORD.
- Latency and throughput:
  - Word accepted at edge n; bytes written at edges n+1 .. n+4.
  - wr_ready high again at cycle n+5 (WAIT_WORD).
  - Maximum throughput is 1 word per 5 cycles.
- Outside WRITE: mem_we=0. mem_addr and mem_wdata hold their last values (don't-care).
- DONE: done=1, busy=0, wr_ready=0; held until start or reset.
- ERR: error=1, busy=0, wr_ready=0; held until start or reset.
- Source stall: wr_valid=0 in WAIT_WORD waits indefinitely; there is no timeout.
- A word held on wr_valid through WRITE is not accepted until wr_ready returns, so it is never duplicated.
- Exactly filling the RAM with a wr_last word gives DONE, not ERR.
- word_count wraps to 0 after a full-RAM session of RAM_DEPTH/4 words. Full sessions are detected by done together with the full flag, not by word_count.
- mem_wdata is registered with mem_we and mem_addr (all from the same state register); there is no combinational path from wr_word to the RAM port.

Test Plan:
- start, base_addr=0; words 0x08000005, 0x0020502A (wr_last) -> mem_we bytes at addr 0..7 = 08,00,00,05,00,20,50,2A; done=1, word_count=2, error=0.
- start, base_addr=6; one word 0x00201020 with wr_last -> writes at addr 4..7 = 00,20,10,20 (base aligned to 4); done=1.
- wr_valid held high continuously with 3 distinct words, last on third -> exactly 12 mem_we pulses; wr_ready low 4 cycles after each accept; 5-cycle spacing between accepts; no repeated word.
- start, base_addr=60; two words, neither last -> first word written at 60..63; second accepted then discarded with no mem_we; error=1, word_count=1, busy=0.
- rst_n=0 on the cycle after the byte-1 write of a word -> next cycle mem_we=0, busy=0, wr_ready=0, word_count=0; a following start with base_addr=0 loads normally.
- start pulsed in WRITE -> ignored, session continues; start pulsed in DONE -> done and word_count clear, busy=1, wr_ready=1 next cycle.
